// File: rtl/bus_round_robin_arbiter.sv
// Round-robin bus arbiter: one-hot grant, top-address slave decode, burst beat
// counting against bus_wait, wait-timeout abort reported on bus_error.
module bus_round_robin_arbiter #(
  parameter int NUM_MASTERS = 8,
  parameter int NUM_SLAVES  = 8,
  parameter int A_WIDTH     = 32,
  parameter int SEL_BITS    = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         req,
  output logic [NUM_MASTERS-1:0]         ack,
  input  logic [A_WIDTH-1:0]             bus_addr,
  input  logic [1:0]                     bus_burst_length,
  input  logic                           bus_wait,
  output logic [NUM_SLAVES-1:0]          device_en,
  output logic                           busy,
  output logic                           bus_error,
  output logic [$clog2(NUM_MASTERS)-1:0] owner_id
);

  localparam int OW = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {IDLE, GRANT, XFER, RELEASE} state_t;

  state_t                state_q, state_d;
  logic [NUM_MASTERS-1:0] ack_q, ack_d;
  logic [NUM_SLAVES-1:0]  device_en_q, device_en_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic [2:0]             beats_left_q, beats_left_d;
  logic [7:0]             wait_cnt_q, wait_cnt_d;
  logic                   bus_error_q, bus_error_d;

  logic [OW-1:0]          winner;
  logic                   found;
  logic [SEL_BITS-1:0]    sel;
  logic [2:0]             burst_beats;
  logic                   unused_addr_bits;

  assign sel              = bus_addr[A_WIDTH-1 -: SEL_BITS];
  assign unused_addr_bits = ^bus_addr[A_WIDTH-SEL_BITS-1:0];

  // Search upward from the master after the last owner, wrapping around.
  always_comb begin
    int idx;
    winner = owner_q;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = int'(owner_q) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && req[OW'(idx)]) begin
        found  = 1'b1;
        winner = OW'(idx);
      end
    end
  end

  always_comb begin
    case (bus_burst_length)
      2'd0:    burst_beats = 3'd0;
      2'd1:    burst_beats = 3'd1;
      2'd2:    burst_beats = 3'd3;
      default: burst_beats = 3'd7;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ack_d        = ack_q;
    device_en_d  = device_en_q;
    owner_d      = owner_q;
    beats_left_d = beats_left_q;
    wait_cnt_d   = wait_cnt_q;
    bus_error_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          ack_d   = NUM_MASTERS'(1) << winner;
          owner_d = winner;
          state_d = GRANT;
        end
      end
      GRANT: begin
        beats_left_d = burst_beats;
        wait_cnt_d   = 8'd0;
        if (int'(sel) < NUM_SLAVES) begin
          device_en_d = NUM_SLAVES'(1) << sel;
          state_d     = XFER;
        end else begin
          bus_error_d = 1'b1;
          ack_d       = '0;
          state_d     = RELEASE;
        end
      end
      XFER: begin
        // A requester withdrawing mid-burst ends the tenure quietly.
        if (!req[owner_q]) begin
          ack_d       = '0;
          device_en_d = '0;
          state_d     = RELEASE;
        end else if (!bus_wait) begin
          if (beats_left_q == 3'd0) begin
            ack_d       = '0;
            device_en_d = '0;
            state_d     = RELEASE;
          end else begin
            beats_left_d = beats_left_q - 3'd1;
            wait_cnt_d   = 8'd0;
          end
        end else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
          bus_error_d = 1'b1;
          ack_d       = '0;
          device_en_d = '0;
          state_d     = RELEASE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      RELEASE: begin
        ack_d       = '0;
        device_en_d = '0;
        state_d     = IDLE;
      end
      default: begin
        ack_d       = '0;
        device_en_d = '0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ack_q        <= '0;
      device_en_q  <= '0;
      owner_q      <= OW'(NUM_MASTERS - 1);
      beats_left_q <= 3'd0;
      wait_cnt_q   <= 8'd0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      device_en_q  <= device_en_d;
      owner_q      <= owner_d;
      beats_left_q <= beats_left_d;
      wait_cnt_q   <= wait_cnt_d;
      bus_error_q  <= bus_error_d;
    end
  end

  assign ack       = ack_q;
  assign device_en = device_en_q;
  assign owner_id  = owner_q;
  assign bus_error = bus_error_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bus_round_robin_arbiter.sv
// Scoreboard bench: directed tenures push expected bus events; a negedge
// monitor pops and compares them as grants, enables and errors appear.
module tb_bus_round_robin_arbiter;

  localparam int K_GRANT  = 0;
  localparam int K_DEV    = 1;
  localparam int K_DEVLEN = 2;
  localparam int K_ERR    = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  req;
  logic [7:0]  ack;
  logic [31:0] bus_addr;
  logic [1:0]  bus_burst_length;
  logic        bus_wait;
  logic [4:0]  device_en;
  logic        busy;
  logic        bus_error;
  logic [2:0]  owner_id;

  typedef struct {
    int kind;
    int val;
    int owner;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  bus_round_robin_arbiter #(
    .NUM_MASTERS(8), .NUM_SLAVES(5), .A_WIDTH(32), .SEL_BITS(3), .TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .ack(ack), .bus_addr(bus_addr),
    .bus_burst_length(bus_burst_length), .bus_wait(bus_wait),
    .device_en(device_en), .busy(busy), .bus_error(bus_error), .owner_id(owner_id)
  );

  always #5 clk = ~clk;

  function automatic string kindName(int k);
    case (k)
      K_GRANT:  return "grant";
      K_DEV:    return "device_en";
      K_DEVLEN: return "device_en_cycles";
      default:  return "bus_error";
    endcase
  endfunction

  task automatic pushExpect(int kind, int val, int owner, int gap);
    exp_t e;
    e.kind = kind; e.val = val; e.owner = owner; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(logic [7:0] r, logic [31:0] a, logic [1:0] b, logic w);
    req = r; bus_addr = a; bus_burst_length = b; bus_wait = w;
  endtask

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDev(bit want);
    bit done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      stepCycle();
      if ((device_en != '0) == want) done = 1'b1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL wait_device_en: timed out, required device_en active=%0d", want);
    end
  endtask

  task automatic waitErr();
    bit done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      stepCycle();
      if (bus_error === 1'b1) done = 1'b1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL wait_bus_error: timed out, required a bus_error pulse");
    end
  endtask

  task automatic compareEvent(int kind, int val, int own, int gap);
    exp_t e;
    bit   bad;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL unexpected_%s: got value 0x%0h owner %0d, required no event",
               kindName(kind), val, own);
    end else begin
      e   = exp_q.pop_front();
      bad = (e.kind != kind) || (e.val != val) ||
            (kind == K_GRANT && e.owner != own) ||
            (kind == K_GRANT && e.gap >= 0 && e.gap != gap);
      if (bad) begin
        miscompares++;
        $display("[TB] FAIL event_%s: got %s val 0x%0h owner %0d gap %0d, required %s val 0x%0h owner %0d gap %0d",
                 kindName(e.kind), kindName(kind), val, own, gap,
                 kindName(e.kind), e.val, e.owner, e.gap);
      end
    end
  endtask

  // Monitor: detects grant/enable edges and error pulses on the falling edge.
  initial begin
    logic [7:0] pa;
    logic [4:0] pd;
    int dcnt;
    int zcnt;
    pa = '0; pd = '0; dcnt = 0; zcnt = 0;
    forever begin
      @(negedge clk);
      if (ack != '0 && pa == '0) compareEvent(K_GRANT, int'(ack), int'(owner_id), zcnt);
      if (device_en != '0 && pd == '0) compareEvent(K_DEV, int'(device_en), 0, 0);
      if (device_en == '0 && pd != '0) compareEvent(K_DEVLEN, dcnt, 0, 0);
      if (bus_error === 1'b1) compareEvent(K_ERR, 1, 0, 0);
      dcnt = (device_en != '0) ? ((pd == '0) ? 1 : dcnt + 1) : 0;
      zcnt = (ack == '0) ? zcnt + 1 : 0;
      pa = ack;
      pd = device_en;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(8'h00, 32'h0, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_ack", ack, 0);
    checkOutput("reset_device_en", device_en, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_bus_error", bus_error, 0);
    checkOutput("reset_owner_id", owner_id, 7);

    // Master 0 then the CPU, single beats to RAM.
    pushExpect(K_GRANT, 8'h01, 0, -1);
    pushExpect(K_DEV, 5'h02, 0, 0);
    pushExpect(K_DEVLEN, 1, 0, 0);
    pushExpect(K_GRANT, 8'h80, 7, 2);
    pushExpect(K_DEV, 5'h02, 0, 0);
    pushExpect(K_DEVLEN, 1, 0, 0);
    applyStimulus(8'h81, 32'h2000_0000, 2'd0, 1'b0);
    stepCycle();
    checkOutput("t1_ack_latency", ack, 8'h01);
    checkOutput("t1_dev_not_yet", device_en, 0);
    stepCycle();
    checkOutput("t1_dev_latency", device_en, 5'h02);
    checkOutput("t1_owner", owner_id, 0);
    waitDev(1'b0);
    applyStimulus(8'h80, 32'h2000_0000, 2'd0, 1'b0);
    waitDev(1'b1);
    waitDev(1'b0);
    applyStimulus(8'h00, 32'h2000_0000, 2'd0, 1'b0);

    // Three held requesters rotate 0,2,3,0,2,3.
    for (int k = 0; k < 6; k++) begin
      int o;
      o = (k % 3 == 0) ? 0 : ((k % 3 == 1) ? 2 : 3);
      pushExpect(K_GRANT, 1 << o, o, (k == 0) ? -1 : 2);
      pushExpect(K_DEV, 5'h01, 0, 0);
      pushExpect(K_DEVLEN, 1, 0, 0);
    end
    applyStimulus(8'h0D, 32'h0000_0000, 2'd0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      waitDev(1'b1);
      waitDev(1'b0);
    end
    applyStimulus(8'h00, 32'h0000_0000, 2'd0, 1'b0);

    // 8-beat burst with two 2-cycle stalls: enable held 12 cycles.
    pushExpect(K_GRANT, 8'h02, 1, -1);
    pushExpect(K_DEV, 5'h01, 0, 0);
    pushExpect(K_DEVLEN, 12, 0, 0);
    applyStimulus(8'h02, 32'h0000_0000, 2'd3, 1'b0);
    waitDev(1'b1);
    bus_wait = 1'b1;
    repeat (2) stepCycle();
    bus_wait = 1'b0;
    repeat (4) stepCycle();
    bus_wait = 1'b1;
    repeat (2) stepCycle();
    bus_wait = 1'b0;
    waitDev(1'b0);
    applyStimulus(8'h00, 32'h0000_0000, 2'd0, 1'b0);

    // Stall timeout on master 4, then master 5 gets the bus.
    pushExpect(K_GRANT, 8'h10, 4, -1);
    pushExpect(K_DEV, 5'h04, 0, 0);
    pushExpect(K_DEVLEN, 4, 0, 0);
    pushExpect(K_ERR, 1, 0, 0);
    pushExpect(K_GRANT, 8'h20, 5, 2);
    pushExpect(K_DEV, 5'h04, 0, 0);
    pushExpect(K_DEVLEN, 1, 0, 0);
    applyStimulus(8'h30, 32'h4000_0000, 2'd0, 1'b1);
    waitErr();
    checkOutput("t4_ack_cleared", ack, 0);
    checkOutput("t4_dev_cleared", device_en, 0);
    applyStimulus(8'h20, 32'h4000_0000, 2'd0, 1'b0);
    waitDev(1'b1);
    waitDev(1'b0);
    applyStimulus(8'h00, 32'h4000_0000, 2'd0, 1'b0);

    // Slave ID 7 is beyond the five slaves: error, no enable.
    pushExpect(K_GRANT, 8'h01, 0, -1);
    pushExpect(K_ERR, 1, 0, 0);
    applyStimulus(8'h01, 32'hE000_0000, 2'd0, 1'b0);
    waitErr();
    checkOutput("t5_ack_cleared", ack, 0);
    checkOutput("t5_dev_zero", device_en, 0);
    checkOutput("t5_busy_release", busy, 1);
    applyStimulus(8'h00, 32'hE000_0000, 2'd0, 1'b0);
    stepCycle();
    checkOutput("t5_busy_idle", busy, 0);

    // Reset after beat 2 of a 4-beat burst; master 0 wins afterwards.
    pushExpect(K_GRANT, 8'h02, 1, -1);
    pushExpect(K_DEV, 5'h02, 0, 0);
    pushExpect(K_DEVLEN, 3, 0, 0);
    pushExpect(K_GRANT, 8'h01, 0, -1);
    pushExpect(K_DEV, 5'h02, 0, 0);
    pushExpect(K_DEVLEN, 4, 0, 0);
    applyStimulus(8'h02, 32'h2000_0000, 2'd2, 1'b0);
    waitDev(1'b1);
    repeat (2) stepCycle();
    reset = 1'b1;
    stepCycle();
    checkOutput("t6_reset_ack", ack, 0);
    checkOutput("t6_reset_dev", device_en, 0);
    checkOutput("t6_reset_owner", owner_id, 7);
    checkOutput("t6_reset_busy", busy, 0);
    reset = 1'b0;
    applyStimulus(8'h03, 32'h2000_0000, 2'd2, 1'b0);
    waitDev(1'b1);
    waitDev(1'b0);
    applyStimulus(8'h00, 32'h2000_0000, 2'd0, 1'b0);

    repeat (5) stepCycle();
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("[TB] FAIL missing_%s: got no event, required val 0x%0h owner %0d",
               kindName(e.kind), e.val, e.owner);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
